// File: rtl/mc_controller_if.sv
// Control bundle between the multi-cycle controller and the accumulator datapath.
// The master drives the controls; the slave supplies the decoded IR fields and the zero flag.
interface mc_controller_if;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       zero;
    logic       pc_load;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;

    modport master (
        input  opcode, funct, zero,
        output pc_load, pc_src, i_or_d, mem_read, mem_write, ir_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_load, pc_src, i_or_d, mem_read, mem_write, ir_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op
    );
endinterface

// File: rtl/mc_controller.sv
// Moore multi-cycle control FSM for the 16-bit accumulator MIPS datapath.
// Controls are registered alongside the state and forced to 0 while rst is low.
module mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    mc_controller_if.master    bus,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        LD_MEM = STATE_W'(2),
        LD_WB  = STATE_W'(3),
        ST     = STATE_W'(4),
        JMP    = STATE_W'(5),
        BRZ    = STATE_W'(6),
        RT_EX  = STATE_W'(7),
        RT_WB  = STATE_W'(8),
        IMM_EX = STATE_W'(9),
        IMM_WB = STATE_W'(10)
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctrl_t;

    state_t state_q;
    state_t nxt;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl;

    function automatic state_t next_state(input state_t st, input logic [3:0] op,
                                          input logic [2:0] fn);
        state_t n;
        n = FETCH;
        case (st)
            FETCH:  n = DECODE;
            DECODE: begin
                casez (op)
                    4'b0000: n = LD_MEM;
                    4'b0001: n = ST;
                    4'b0010: n = JMP;
                    4'b0100: n = BRZ;
                    4'b1000: n = RT_EX;
                    4'b11??: n = IMM_EX;
                    default: n = FETCH;
                endcase
            end
            LD_MEM: n = LD_WB;
            RT_EX:  n = (fn <= 3'b101) ? RT_WB : FETCH;
            IMM_EX: n = IMM_WB;
            default: n = FETCH;
        endcase
        return n;
    endfunction

    // Controls for the state about to be entered; IR fields are stable by then.
    function automatic ctrl_t decode(input state_t st, input logic [3:0] op,
                                     input logic [2:0] fn);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            DECODE: c.alu_src_b = 2'b10;
            LD_MEM: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            LD_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
            end
            ST: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            JMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            BRZ: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b11;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            RT_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = fn;
            end
            RT_WB:  c.reg_write = 1'b1;
            IMM_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = {1'b0, op[1:0]};
            end
            IMM_WB: c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb nxt = next_state(state_q, bus.opcode, bus.funct);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            ctrl_q  <= decode(FETCH, 4'd0, 3'd0);
        end else begin
            state_q <= nxt;
            ctrl_q  <= decode(nxt, bus.opcode, bus.funct);
        end
    end

    // Holding FETCH controls in reset lets the first edge after release perform the fetch.
    always_comb ctrl = rst ? ctrl_q : '0;

    assign bus.pc_load    = ctrl.pc_write | (ctrl.branch & bus.zero);
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.i_or_d     = ctrl.i_or_d;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;
    assign state          = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its state
// sequence and checks state plus the full control vector against hand-derived values.
module tb_mc_controller;

    logic       clk;
    logic       rst;
    logic [3:0] state;
    int         checks;
    int         errors;

    mc_controller_if bus ();

    mc_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] obs_ctrl;
    assign obs_ctrl = {bus.pc_load, bus.pc_src, bus.i_or_d, bus.mem_read, bus.mem_write,
                       bus.ir_write, bus.reg_write, bus.mem_to_reg, bus.alu_src_a,
                       bus.alu_src_b, bus.alu_op};

    function automatic logic [15:0] cv(input logic pl, input logic [1:0] ps, input logic iod,
                                       input logic mr, input logic mw, input logic iw,
                                       input logic rw, input logic [1:0] m2r, input logic sa,
                                       input logic [1:0] sb, input logic [2:0] op);
        return {pl, ps, iod, mr, mw, iw, rw, m2r, sa, sb, op};
    endfunction

    logic [15:0] c_fetch, c_decode, c_ldmem, c_ldwb, c_st, c_jmp, c_brz_t, c_brz_n, c_wb;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_sc(input string tag, input logic [3:0] st, input logic [15:0] c);
        chk({tag, "_state"}, {12'd0, state}, {12'd0, st});
        chk({tag, "_ctrl"}, obs_ctrl, c);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        c_fetch    = cv(1, 2'b00, 0, 1, 0, 1, 0, 2'b00, 0, 2'b01, 3'b000);
        c_decode   = cv(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 3'b000);
        c_ldmem    = cv(0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000);
        c_ldwb     = cv(0, 2'b00, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 3'b000);
        c_st       = cv(0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000);
        c_jmp      = cv(1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000);
        c_brz_t    = cv(1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 2'b11, 3'b000);
        c_brz_n    = cv(0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 1, 2'b11, 3'b000);
        c_wb       = cv(0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 3'b000);
        rst        = 1'b0;
        bus.opcode = 4'b0000;
        bus.funct  = 3'b000;
        bus.zero   = 1'b0;

        // Reset held across three edges
        repeat (3) begin
            step();
            expect_sc("reset", 4'd0, 16'h0000);
        end
        rst = 1'b1;
        #1;
        expect_sc("fetch_after_reset", 4'd0, c_fetch);

        // LOAD
        bus.opcode = 4'b0000;
        step(); expect_sc("ld_decode", 4'd1, c_decode);
        step(); expect_sc("ld_mem", 4'd2, c_ldmem);
        step(); expect_sc("ld_wb", 4'd3, c_ldwb);
        step(); expect_sc("ld_fetch", 4'd0, c_fetch);

        // STORE
        bus.opcode = 4'b0001;
        step(); expect_sc("st_decode", 4'd1, c_decode);
        step(); expect_sc("st_exec", 4'd4, c_st);
        step(); expect_sc("st_fetch", 4'd0, c_fetch);

        // JUMP
        bus.opcode = 4'b0010;
        step(); expect_sc("jmp_decode", 4'd1, c_decode);
        step(); expect_sc("jmp_exec", 4'd5, c_jmp);
        step(); expect_sc("jmp_fetch", 4'd0, c_fetch);

        // BRZ taken, then the same state with zero dropped
        bus.opcode = 4'b0100;
        bus.zero   = 1'b1;
        step(); expect_sc("brz_t_decode", 4'd1, c_decode);
        step(); expect_sc("brz_taken", 4'd6, c_brz_t);
        bus.zero = 1'b0;
        #1;
        expect_sc("brz_zero_drop", 4'd6, c_brz_n);
        step(); expect_sc("brz_t_fetch", 4'd0, c_fetch);

        // BRZ not taken
        step(); expect_sc("brz_n_decode", 4'd1, c_decode);
        step(); expect_sc("brz_not_taken", 4'd6, c_brz_n);
        step(); expect_sc("brz_n_fetch", 4'd0, c_fetch);

        // R-type sub
        bus.opcode = 4'b1000;
        bus.funct  = 3'b001;
        step(); expect_sc("rt_sub_decode", 4'd1, c_decode);
        step(); expect_sc("rt_sub_ex", 4'd7, cv(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b001));
        step(); expect_sc("rt_sub_wb", 4'd8, c_wb);
        step(); expect_sc("rt_sub_fetch", 4'd0, c_fetch);

        // R-type not: highest legal funct still writes back
        bus.funct = 3'b101;
        step(); expect_sc("rt_not_decode", 4'd1, c_decode);
        step(); expect_sc("rt_not_ex", 4'd7, cv(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b101));
        step(); expect_sc("rt_not_wb", 4'd8, c_wb);
        step(); expect_sc("rt_not_fetch", 4'd0, c_fetch);

        // R-type illegal funct 110 and 111: no writeback
        bus.funct = 3'b110;
        step(); expect_sc("rt_f6_decode", 4'd1, c_decode);
        step(); expect_sc("rt_f6_ex", 4'd7, cv(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b110));
        step(); expect_sc("rt_f6_fetch", 4'd0, c_fetch);
        bus.funct = 3'b111;
        step(); expect_sc("rt_f7_decode", 4'd1, c_decode);
        step(); expect_sc("rt_f7_ex", 4'd7, cv(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b111));
        step(); expect_sc("rt_f7_fetch", 4'd0, c_fetch);

        // Immediate and
        bus.opcode = 4'b1110;
        bus.funct  = 3'b000;
        step(); expect_sc("imm_and_decode", 4'd1, c_decode);
        step(); expect_sc("imm_and_ex", 4'd9, cv(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010));
        step(); expect_sc("imm_and_wb", 4'd10, c_wb);
        step(); expect_sc("imm_and_fetch", 4'd0, c_fetch);

        // Immediate sub
        bus.opcode = 4'b1101;
        step(); expect_sc("imm_sub_decode", 4'd1, c_decode);
        step(); expect_sc("imm_sub_ex", 4'd9, cv(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b001));
        step(); expect_sc("imm_sub_wb", 4'd10, c_wb);
        step(); expect_sc("imm_sub_fetch", 4'd0, c_fetch);

        // Illegal opcodes fall straight back to FETCH
        bus.opcode = 4'b0111;
        step(); expect_sc("ill7_decode", 4'd1, c_decode);
        step(); expect_sc("ill7_fetch", 4'd0, c_fetch);
        bus.opcode = 4'b1001;
        step(); expect_sc("ill9_decode", 4'd1, c_decode);
        step(); expect_sc("ill9_fetch", 4'd0, c_fetch);

        // Asynchronous reset in LD_MEM aborts the load before writeback
        bus.opcode = 4'b0000;
        step(); expect_sc("mrst_decode", 4'd1, c_decode);
        step(); expect_sc("mrst_ldmem", 4'd2, c_ldmem);
        #2;
        rst = 1'b0;
        #1;
        expect_sc("mrst_async", 4'd0, 16'h0000);
        step(); expect_sc("mrst_held", 4'd0, 16'h0000);
        rst = 1'b1;
        #1;
        expect_sc("mrst_release", 4'd0, c_fetch);
        step(); expect_sc("mrst_decode2", 4'd1, c_decode);
        step(); expect_sc("mrst_ldmem2", 4'd2, c_ldmem);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Moore-style multi-cycle control FSM for the 16-bit accumulator MIPS datapath.
- Decodes the instruction register and sequences the register file, ALU, memory and PC mux/enable controls in the datapath.
- Consumes the ALU zero flag and drives the ALU select code and every datapath mux select and write enable.
- Sits directly upstream of the datapath: PC/IR/MDR/A/B/ALUOut registers, ALU, mux2/mux3/mux4, sign extender.

Parameters:
- STATE_W, 4, width of the state register and debug state port.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  4  IR[15:12].
- funct  in  3  IR[2:0]; R-type function code.
- zero  in  1  ALU zero flag, current cycle.
- pc_load  out  1  PC register write enable = pc_write | (branch & zero).
- pc_src  out  2  PC mux: 00 ALU result, 01 ALUOut, 10 jump address {PC[15:12], IR[11:0]}.
- i_or_d  out  1  memory address mux: 0 PC, 1 {PC[15:12], IR[11:0]}.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- ir_write  out  1  IR write enable.
- reg_write  out  1  register file write enable (destination is always R0).
- mem_to_reg  out  2  write-data mux: 00 ALUOut, 01 MDR.
- alu_src_a  out  1  ALU A mux: 0 PC, 1 A register (R0).
- alu_src_b  out  2  ALU B mux: 00 B register, 01 constant 1, 10 sign-extended IR[11:0], 11 constant 0.
- alu_op  out  3  ALU select; same codes as ALU (000 add, 001 sub, 010 and, 011 or, 100 slt, 101 not).
- state  out  4  current state, for debug and verification.

Behaviour:
- Reset
  - rst low forces state to FETCH (0) immediately, without waiting for a clock edge.
  - While rst is low, every control output is 0, including during FETCH.
  - The first FETCH actions occur on the first rising edge after rst is released.
  - rst asserted mid-instruction aborts the instruction. No partial writes may be issued after rst falls.
- Outputs are decoded from state only; zero enters only through pc_load. Unlisted outputs are 0 in each state.
- States and encodings, with outputs and transitions:
  - FETCH=0: mem_read, ir_write, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00, pc_write. Next: DECODE.
  - DECODE=1: alu_src_a=0, alu_src_b=10, alu_op=000 (precomputes branch target into ALUOut). Next state by opcode:
    - 0000 → LD_MEM
    - 0001 → ST
    - 0010 → JMP
    - 0100 → BRZ
    - 1000 → RT_EX
    - 11xx → IMM_EX
    - any other opcode → FETCH (NOP).
  - LD_MEM=2: i_or_d=1, mem_read. Next: LD_WB.
  - LD_WB=3: reg_write, mem_to_reg=01. Next: FETCH.
  - ST=4: i_or_d=1, mem_write. Next: FETCH.
  - JMP=5: pc_src=10, pc_write. Next: FETCH.
  - BRZ=6: alu_src_a=1, alu_src_b=11, alu_op=000, pc_src=01, branch. Branch is taken iff R0==0. Next: FETCH.
  - RT_EX=7: alu_src_a=1, alu_src_b=00, alu_op=funct. Next: RT_WB if funct ≤ 101; otherwise FETCH with no writeback.
  - RT_WB=8: reg_write, mem_to_reg=00. Next: FETCH.
  - IMM_EX=9: alu_src_a=1, alu_src_b=10, alu_op={1'b0, opcode[1:0]} (1100 add, 1101 sub, 1110 and, 1111 or). Next: IMM_WB.
  - IMM_WB=10: reg_write, mem_to_reg=00. Next: FETCH.
- Latency in cycles, counted from FETCH to the next FETCH:
  - LD: 4. ST, JMP, BRZ: 3. RT and IMM: 4. Illegal opcode: 2. RT with illegal funct: 3.
- Never asserted together: mem_read with mem_write, or reg_write with mem_write.
- Unreachable encodings 11–15 return to FETCH on the next edge with all outputs 0.
- opcode and funct are sampled only in DECODE and RT_EX. The IR is stable outside FETCH.

Test Plan:
- Reset: hold rst low for 3 edges, then release → state=0 and all outputs 0 during reset. First post-reset cycle shows mem_read=1, ir_write=1, pc_load=1, alu_src_b=01.
- LOAD (opcode 0000) → state sequence 0,1,2,3,0. i_or_d=1 with mem_read=1 in state 2. reg_write=1, mem_to_reg=01 in state 3.
- BRZ (opcode 0100):
  - zero=1 in state 6 → pc_load=1, pc_src=01.
  - Repeat with zero=0 → pc_load=0. Both cases return to FETCH after 3 cycles.
- R-type:
  - opcode 1000, funct 001 → alu_op=001 in state 7, then reg_write in state 8.
  - funct 111 → sequence 0,1,7,0, with reg_write never asserted.
- IMM and illegal opcodes:
  - opcode 1110 → alu_op=010, alu_src_b=10 in state 9.
  - opcode 0111 → sequence 0,1,0, with no write enable beyond FETCH.
- Mid-operation reset: drop rst asynchronously during LD_MEM → state=0 and mem_read=0 before the next edge. reg_write is never asserted.
